// File: rtl/voice_serializer_pkg.sv
// voice_serializer_pkg
//   Shared constants and types for the voice bus serializer: default slot count,
//   sample width, slot index width, slot index type and the serializer FSM encoding.
package voice_serializer_pkg;

    localparam int N_VOICES = 10;
    localparam int SAMPLE_W = 24;
    localparam int IDX_W    = 4;

    typedef logic [IDX_W-1:0] slot_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } vser_state_t;

endpackage

// File: rtl/voice_snapshot_bank.sv
// voice_snapshot_bank
//   N_VOICES x DATA_W register file holding one frame of voice samples.
//   Loads all voices in parallel on capture; voices whose keep_mask bit is 0
//   are stored as zero. Read port is combinational, addressed by rd_idx.
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset, clears every entry
//   capture    parallel load strobe
//   voices     packed samples, voice k at [k*DATA_W +: DATA_W]
//   keep_mask  per-voice keep bit (0 stores zero)
//   rd_idx     read address
//   rd_data    sample at rd_idx
module voice_snapshot_bank
    import voice_serializer_pkg::*;
#(
    parameter int N_VOICES = voice_serializer_pkg::N_VOICES,
    parameter int DATA_W   = voice_serializer_pkg::SAMPLE_W,
    parameter int IDX_W    = voice_serializer_pkg::IDX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         capture,
    input  logic [N_VOICES*DATA_W-1:0]   voices,
    input  logic [N_VOICES-1:0]          keep_mask,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [DATA_W-1:0]            rd_data
);

    logic [DATA_W-1:0] bank [N_VOICES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_VOICES; k++) begin
                bank[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N_VOICES; k++) begin
                bank[k] <= keep_mask[k] ? voices[k*DATA_W +: DATA_W] : '0;
            end
        end
    end

    assign rd_data = bank[rd_idx];

endmodule

// File: rtl/voice_serializer.sv
// voice_serializer
//   Producer side of the time-multiplexed voice bus feeding the 10-slot mixer.
//   A frame tick snapshots every voice; the frame is then emitted one slot per
//   cycle on o_data with o_clk_en as the slot strobe. i_hold stalls slot issue.
//   Optional build macro VSER_MUTE_EN adds i_voice_active: gated-off voices are
//   captured as zero but their slots are still issued.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_frame_tick    1-cycle strobe starting a frame
//   i_voices        packed signed samples, voice k at [k*DATA_W +: DATA_W]
//   i_hold          consumer stall
//   i_clr_overrun   clears o_overrun
//   i_voice_active  per-voice gate (VSER_MUTE_EN only)
//   o_data/o_slot   current slot sample and index
//   o_clk_en        slot-valid strobe
//   o_last          slot-valid on the final slot
//   o_busy          frame in progress
//   o_overrun       sticky: tick arrived while a frame was still being sent
//
// state   | meaning
// ST_IDLE | waiting for a frame tick
// ST_SEND | issuing slots idx..N_VOICES-1 from the snapshot bank
module voice_serializer
    import voice_serializer_pkg::*;
#(
    parameter int N_VOICES = voice_serializer_pkg::N_VOICES,
    parameter int DATA_W   = voice_serializer_pkg::SAMPLE_W,
    parameter int IDX_W    = voice_serializer_pkg::IDX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_frame_tick,
    input  logic [N_VOICES*DATA_W-1:0]   i_voices,
    input  logic                         i_hold,
    input  logic                         i_clr_overrun,
`ifdef VSER_MUTE_EN
    input  logic [N_VOICES-1:0]          i_voice_active,
`endif
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_clk_en,
    output logic [IDX_W-1:0]             o_slot,
    output logic                         o_last,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    vser_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 capture;
    logic                 issue;
    logic                 ovr_set;
    logic [DATA_W-1:0]    rd_data;
    logic [N_VOICES-1:0]  keep_mask;

`ifdef VSER_MUTE_EN
    assign keep_mask = i_voice_active;
`else
    assign keep_mask = '1;
`endif

    voice_snapshot_bank #(
        .N_VOICES (N_VOICES),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .voices    (i_voices),
        .keep_mask (keep_mask),
        .rd_idx    (idx_q),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        issue   = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_tick) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_hold) begin
                    issue = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // A tick coinciding with the final slot chains the next
                        // frame with no gap; the bank is read before it reloads.
                        if (i_frame_tick) begin
                            capture = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (i_frame_tick && !(issue && idx_q == LAST_IDX)) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data    <= '0;
            o_slot    <= '0;
            o_clk_en  <= 1'b0;
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (issue) begin
                o_data   <= rd_data;
                o_slot   <= idx_q;
                o_clk_en <= 1'b1;
                o_last   <= (idx_q == LAST_IDX);
            end else begin
                o_clk_en <= 1'b0;
                o_last   <= 1'b0;
            end
            o_busy <= (state_d == ST_SEND);
            if (ovr_set) begin
                o_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule
